// File: rtl/mul_share_arb.sv
// N-client arbiter in front of one shared pipelined unsigned multiplier.
// A one-hot tag travels with each operand pair so the product returns to its issuer.
module mul_share_arb #(
    parameter int unsigned NCLI = 2,
    parameter int unsigned AW   = 27,
    parameter int unsigned BW   = 27,
    parameter int unsigned LAT  = 2,
    parameter int unsigned RR   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCLI-1:0]      req,
    input  logic [NCLI-1:0]      lock,
    input  logic [NCLI*AW-1:0]   a,
    input  logic [NCLI*BW-1:0]   b,
    output logic [NCLI-1:0]      gnt,
    output logic [NCLI-1:0]      out_vld,
    output logic [AW+BW-1:0]     out,
    output logic                 busy
);
    localparam int unsigned IW = (NCLI > 1) ? $clog2(NCLI) : 1;
    localparam int unsigned PW = AW + BW;

    logic [IW-1:0]   ptr;
    logic [IW-1:0]   lock_idx;
    logic            lock_vld;
    logic            lock_hit;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   idx;
    logic            found;
    logic            any_gnt;
    logic [AW-1:0]   a_sel;
    logic [BW-1:0]   b_sel;
    logic [AW-1:0]   a_q;
    logic [BW-1:0]   b_q;
    logic [LAT-1:0]  v_q;
    logic [NCLI-1:0] tag_q [LAT];

    // A held lock overrides arbitration only while its owner keeps requesting.
    always_comb begin
        gnt      = '0;
        gidx     = '0;
        idx      = '0;
        found    = 1'b0;
        lock_hit = lock_vld && req[lock_idx];
        if (lock_hit) begin
            gidx  = lock_idx;
            found = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NCLI; i++) begin
                idx = (RR != 0) ? IW'((32'(ptr) + i) % NCLI) : IW'(i);
                if (!found && req[idx]) begin
                    gidx  = idx;
                    found = 1'b1;
                end
            end
        end
        any_gnt = found && reset;
        if (any_gnt) begin
            gnt[gidx] = 1'b1;
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NCLI; i++) begin
            if (gidx == IW'(i)) begin
                a_sel = a[i*AW +: AW];
                b_sel = b[i*BW +: BW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
            a_q      <= '0;
            b_q      <= '0;
            v_q      <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            if (any_gnt) begin
                a_q <= a_sel;
                b_q <= b_sel;
                // Lock-held grants leave the rotation pointer untouched.
                if (!lock_hit) begin
                    ptr <= (gidx == IW'(NCLI-1)) ? '0 : gidx + 1'b1;
                end
            end
            lock_vld <= any_gnt && lock[gidx];
            lock_idx <= gidx;
            v_q[0]   <= any_gnt;
            tag_q[0] <= gnt;
            for (int unsigned k = 1; k < LAT; k++) begin
                v_q[k]   <= v_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Data registers load only behind a valid entry, so out keeps the last product.
    generate
        if (LAT == 1) begin : g_lat1
            assign out = PW'(a_q) * PW'(b_q);
        end else begin : g_latn
            logic [PW-1:0] prod_q [1:LAT-1];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int unsigned k = 1; k < LAT; k++) begin
                        prod_q[k] <= '0;
                    end
                end else begin
                    if (v_q[0]) begin
                        prod_q[1] <= PW'(a_q) * PW'(b_q);
                    end
                    for (int unsigned k = 2; k < LAT; k++) begin
                        if (v_q[k-1]) begin
                            prod_q[k] <= prod_q[k-1];
                        end
                    end
                end
            end
            assign out = prod_q[LAT-1];
        end
    endgenerate

    assign out_vld = v_q[LAT-1] ? tag_q[LAT-1] : '0;
    assign busy    = |v_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: a fixed-priority 2-client/LAT=2 instance and a
// round-robin 3-client/LAT=3 instance, checked against a queue-based model.
module tb_mul_share_arb;
    localparam int unsigned W = 27;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]     req_f, lock_f, gnt_f, vld_f;
    logic [2*W-1:0] a_f, b_f, out_f;
    logic           busy_f;
    logic [2:0]     req_r, lock_r, gnt_r, vld_r;
    logic [3*W-1:0] a_r, b_r;
    logic [2*W-1:0] out_r;
    logic           busy_r;

    mul_share_arb #(.NCLI(2), .AW(W), .BW(W), .LAT(2), .RR(0)) u_fp (
        .clk(clk), .reset(rst_n), .req(req_f), .lock(lock_f), .a(a_f), .b(b_f),
        .gnt(gnt_f), .out_vld(vld_f), .out(out_f), .busy(busy_f));

    mul_share_arb #(.NCLI(3), .AW(W), .BW(W), .LAT(3), .RR(1)) u_rr (
        .clk(clk), .reset(rst_n), .req(req_r), .lock(lock_r), .a(a_r), .b(b_r),
        .gnt(gnt_r), .out_vld(vld_r), .out(out_r), .busy(busy_r));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [2:0]  tag;
        logic [53:0] p;
    } ent_t;
    ent_t q_f[$];
    ent_t q_r[$];

    bit lv_f, lv_r;
    int li_f, li_r, ptr_r;
    int g_f, g_r;
    logic [1:0]  e_gnt_f, e_vld_f;
    logic [2:0]  e_gnt_r, e_vld_r;
    logic [53:0] e_out_f, e_out_r;
    logic        e_busy_f, e_busy_r;

    // Winner index from the arbitration rules, or -1 for no grant.
    function automatic int pick(input logic [7:0] rq, input int n, input bit rr,
                                input int ptr, input bit lv, input int li);
        if (lv && rq[li]) return li;
        for (int i = 0; i < n; i++) begin
            int j;
            j = rr ? (ptr + i) % n : i;
            if (rq[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q_f.delete();
        q_r.delete();
        lv_f = 0; lv_r = 0; li_f = 0; li_r = 0; ptr_r = 0;
        g_f = -1; g_r = -1;
    endtask

    task automatic eval();
        #1;
        g_f = rst_n ? pick(8'(req_f), 2, 1'b0, 0, lv_f, li_f) : -1;
        g_r = rst_n ? pick(8'(req_r), 3, 1'b1, ptr_r, lv_r, li_r) : -1;
        e_gnt_f = (g_f >= 0) ? 2'(1 << g_f) : 2'b00;
        e_gnt_r = (g_r >= 0) ? 3'(1 << g_r) : 3'b000;
        while (q_f.size() > 0 && q_f[0].due < cyc) void'(q_f.pop_front());
        while (q_r.size() > 0 && q_r[0].due < cyc) void'(q_r.pop_front());
        e_vld_f = '0;
        if (q_f.size() > 0 && q_f[0].due == cyc) begin
            e_vld_f = q_f[0].tag[1:0];
            e_out_f = q_f[0].p;
        end
        e_vld_r = '0;
        if (q_r.size() > 0 && q_r[0].due == cyc) begin
            e_vld_r = q_r[0].tag;
            e_out_r = q_r[0].p;
        end
        e_busy_f = q_f.size() > 0;
        e_busy_r = q_r.size() > 0;
    endtask

    task automatic tick();
        bit hit;
        if (g_f >= 0) begin
            q_f.push_back('{cyc + 2, 3'(1 << g_f), 54'(a_f[g_f*W +: W]) * 54'(b_f[g_f*W +: W])});
            lv_f = lock_f[g_f];
            li_f = g_f;
        end else begin
            lv_f = 0;
        end
        if (g_r >= 0) begin
            hit = lv_r && req_r[li_r];
            q_r.push_back('{cyc + 3, 3'(1 << g_r), 54'(a_r[g_r*W +: W]) * 54'(b_r[g_r*W +: W])});
            if (!hit) ptr_r = (g_r + 1) % 3;
            lv_r = lock_r[g_r];
            li_r = g_r;
        end else begin
            lv_r = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        req_f = '1; req_r = '1; a_f = '1; b_f = '1; a_r = '1; b_r = '1;
        #1;
        total++; if (gnt_f !== 2'b00) begin bad++; $display("FAIL rst_gnt_f got=%b exp=00", gnt_f); end
        total++; if (gnt_r !== 3'b000) begin bad++; $display("FAIL rst_gnt_r got=%b exp=000", gnt_r); end
        total++; if (vld_f !== 2'b00) begin bad++; $display("FAIL rst_vld_f got=%b exp=00", vld_f); end
        total++; if (vld_r !== 3'b000) begin bad++; $display("FAIL rst_vld_r got=%b exp=000", vld_r); end
        total++; if (out_f !== 54'd0) begin bad++; $display("FAIL rst_out_f got=%h exp=0", out_f); end
        total++; if (out_r !== 54'd0) begin bad++; $display("FAIL rst_out_r got=%h exp=0", out_r); end
        total++; if (busy_f !== 1'b0) begin bad++; $display("FAIL rst_busy_f got=%b exp=0", busy_f); end
        total++; if (busy_r !== 1'b0) begin bad++; $display("FAIL rst_busy_r got=%b exp=0", busy_r); end
        req_f = '0; req_r = '0; a_f = '0; b_f = '0; a_r = '0; b_r = '0;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_single();
        logic [1:0] eg, ev;
        for (int t = 0; t < 4; t++) begin
            req_f = (t == 0) ? 2'b10 : 2'b00;
            a_f = '0; b_f = '0;
            a_f[W +: W] = 27'h1;
            b_f[W +: W] = 27'h3;
            eval();
            eg = (t == 0) ? 2'b10 : 2'b00;
            ev = (t == 2) ? 2'b10 : 2'b00;
            total++; if (gnt_f !== eg) begin bad++; $display("FAIL single_gnt t=%0d got=%b exp=%b", t, gnt_f, eg); end
            total++; if (vld_f !== ev) begin bad++; $display("FAIL single_vld t=%0d got=%b exp=%b", t, vld_f, ev); end
            total++; if (busy_f !== (t == 1 || t == 2)) begin bad++; $display("FAIL single_busy t=%0d got=%b", t, busy_f); end
            if (t == 2) begin
                total++; if (out_f !== 54'd3) begin bad++; $display("FAIL single_out got=%0d exp=3", out_f); end
            end
            tick();
        end
    endtask

    task automatic test_fixed_priority();
        logic [1:0]  eg, ev;
        logic [53:0] ep;
        for (int t = 0; t < 6; t++) begin
            req_f = (t < 3) ? 2'b11 : 2'b00;
            a_f = {27'($urandom), 27'(t + 5)};
            b_f = {27'($urandom), 27'(t + 7)};
            eval();
            eg = (t < 3) ? 2'b01 : 2'b00;
            ev = (t >= 2 && t <= 4) ? 2'b01 : 2'b00;
            total++; if (gnt_f !== eg) begin bad++; $display("FAIL fp_gnt t=%0d got=%b exp=%b", t, gnt_f, eg); end
            total++; if (vld_f !== ev) begin bad++; $display("FAIL fp_vld t=%0d got=%b exp=%b", t, vld_f, ev); end
            if (ev != 0) begin
                ep = 54'((t + 3) * (t + 5));
                total++; if (out_f !== ep) begin bad++; $display("FAIL fp_out t=%0d got=%0d exp=%0d", t, out_f, ep); end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [2:0]  eg, ev;
        logic [53:0] ep;
        int k;
        for (int i = 0; i < 3; i++) begin
            a_r[i*W +: W] = 27'h7FFFFFF;
            b_r[i*W +: W] = 27'h7FFFFFF - 27'(i);
        end
        for (int t = 0; t < 9; t++) begin
            req_r = (t < 6) ? 3'b111 : 3'b000;
            eval();
            eg = (t < 6) ? 3'(1 << (t % 3)) : 3'b000;
            ev = (t >= 3) ? 3'(1 << ((t - 3) % 3)) : 3'b000;
            total++; if (gnt_r !== eg) begin bad++; $display("FAIL rr_gnt t=%0d got=%b exp=%b", t, gnt_r, eg); end
            total++; if (vld_r !== ev) begin bad++; $display("FAIL rr_vld t=%0d got=%b exp=%b", t, vld_r, ev); end
            if (t >= 3) begin
                k  = (t - 3) % 3;
                ep = (k == 0) ? 54'h3FFFFFF0000001 : 54'(27'h7FFFFFF) * 54'(27'h7FFFFFF - 27'(k));
                total++; if (out_r !== ep) begin bad++; $display("FAIL rr_out t=%0d got=%h exp=%h", t, out_r, ep); end
            end
            tick();
        end
    endtask

    task automatic test_lock();
        logic [2:0] rq [6] = '{3'b001, 3'b011, 3'b011, 3'b011, 3'b001, 3'b000};
        logic [2:0] lk [6] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
        logic [2:0] eg [6] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b001, 3'b000};
        for (int t = 0; t < 6; t++) begin
            req_r  = rq[t];
            lock_r = lk[t];
            eval();
            total++; if (gnt_r !== eg[t]) begin bad++; $display("FAIL lock_gnt t=%0d got=%b exp=%b", t, gnt_r, eg[t]); end
            tick();
        end
        lock_r = '0;
        repeat (3) begin eval(); tick(); end
    endtask

    task automatic test_bubble();
        logic [1:0]  ev;
        logic [53:0] ep;
        for (int t = 0; t < 7; t++) begin
            req_f = (t == 0 || t == 2 || t == 3) ? 2'b01 : 2'b00;
            a_f = {27'd0, 27'(t + 2)};
            b_f = {27'd0, 27'(t + 10)};
            eval();
            ev = (t == 2 || t == 4 || t == 5) ? 2'b01 : 2'b00;
            total++; if (vld_f !== ev) begin bad++; $display("FAIL bubble_vld t=%0d got=%b exp=%b", t, vld_f, ev); end
            if (ev != 0) begin
                ep = 54'(t * (t + 8));
                total++; if (out_f !== ep) begin bad++; $display("FAIL bubble_out t=%0d got=%0d exp=%0d", t, out_f, ep); end
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        for (int t = 0; t < 9; t++) begin
            req_r = (t < 2) ? 3'b001 : (t == 5) ? 3'b100 : 3'b000;
            a_r = '0; b_r = '0;
            a_r[0 +: W] = 27'd4; b_r[0 +: W] = 27'd6;
            a_r[2*W +: W] = 27'd9; b_r[2*W +: W] = 27'd11;
            if (t == 3) rst_n = 1'b1;
            eval();
            if (t < 2 || t == 5) begin
                total++; if (gnt_r !== req_r) begin bad++; $display("FAIL rmf_gnt t=%0d got=%b exp=%b", t, gnt_r, req_r); end
            end
            if (t == 2) begin
                total++; if (busy_r !== 1'b1) begin bad++; $display("FAIL rmf_busy_pre got=%b exp=1", busy_r); end
                #2;
                rst_n = 1'b0;
                req_r = 3'b111;
                #1;
                model_reset();
                total++; if (gnt_r !== 3'b000) begin bad++; $display("FAIL rmf_rst_gnt got=%b exp=000", gnt_r); end
                total++; if (busy_r !== 1'b0) begin bad++; $display("FAIL rmf_rst_busy got=%b exp=0", busy_r); end
                total++; if (out_r !== 54'd0) begin bad++; $display("FAIL rmf_rst_out got=%h exp=0", out_r); end
                req_r = 3'b000;
            end
            if (t == 3 || t == 4) begin
                total++; if (vld_r !== 3'b000) begin bad++; $display("FAIL rmf_vld t=%0d got=%b exp=000", t, vld_r); end
                total++; if (busy_r !== 1'b0) begin bad++; $display("FAIL rmf_busy t=%0d got=%b exp=0", t, busy_r); end
            end
            if (t >= 6) begin
                total++; if (vld_r !== ((t == 8) ? 3'b100 : 3'b000)) begin bad++; $display("FAIL rmf_ret t=%0d got=%b", t, vld_r); end
                if (t == 8) begin
                    total++; if (out_r !== 54'd99) begin bad++; $display("FAIL rmf_out got=%0d exp=99", out_r); end
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 406; t++) begin
            if (t < 400) begin
                req_f  = 2'($urandom);
                lock_f = 2'($urandom & $urandom);
                req_r  = 3'($urandom);
                lock_r = 3'($urandom & $urandom);
            end else begin
                req_f = '0; lock_f = '0; req_r = '0; lock_r = '0;
            end
            a_f = 54'({$urandom, $urandom});
            b_f = 54'({$urandom, $urandom});
            a_r = 81'({$urandom, $urandom, $urandom});
            b_r = 81'({$urandom, $urandom, $urandom});
            eval();
            total++; if (gnt_f !== e_gnt_f) begin bad++; $display("FAIL rnd_gnt_f c=%0d got=%b exp=%b", cyc, gnt_f, e_gnt_f); end
            total++; if (vld_f !== e_vld_f) begin bad++; $display("FAIL rnd_vld_f c=%0d got=%b exp=%b", cyc, vld_f, e_vld_f); end
            total++; if (busy_f !== e_busy_f) begin bad++; $display("FAIL rnd_busy_f c=%0d got=%b exp=%b", cyc, busy_f, e_busy_f); end
            if (e_vld_f != 0) begin
                total++; if (out_f !== e_out_f) begin bad++; $display("FAIL rnd_out_f c=%0d got=%h exp=%h", cyc, out_f, e_out_f); end
            end
            total++; if (gnt_r !== e_gnt_r) begin bad++; $display("FAIL rnd_gnt_r c=%0d got=%b exp=%b", cyc, gnt_r, e_gnt_r); end
            total++; if (vld_r !== e_vld_r) begin bad++; $display("FAIL rnd_vld_r c=%0d got=%b exp=%b", cyc, vld_r, e_vld_r); end
            total++; if (busy_r !== e_busy_r) begin bad++; $display("FAIL rnd_busy_r c=%0d got=%b exp=%b", cyc, busy_r, e_busy_r); end
            if (e_vld_r != 0) begin
                total++; if (out_r !== e_out_r) begin bad++; $display("FAIL rnd_out_r c=%0d got=%h exp=%h", cyc, out_r, e_out_r); end
            end
            tick();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req_f  = '0; lock_f = '0; a_f = '0; b_f = '0;
        req_r  = '0; lock_r = '0; a_r = '0; b_r = '0;
        model_reset();
        test_reset();
        test_single();
        test_fixed_priority();
        test_round_robin();
        test_lock();
        test_bubble();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
